// File: rtl/refresh_sched.sv
// refresh_sched: DDR4 tREFI interval timer with postponed-refresh tracking
// and a PREA + REF burst sequencer that runs once the controller grants the bus.
module refresh_sched #(
   parameter int T_REFI       = 6240,
   parameter int ALMOST_LEAD  = 64,
   parameter int T_RP         = 16,
   parameter int T_RFC        = 280,
   parameter int MAX_POSTPONE = 8
) (
   input  logic       CK_t,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       refresh_grant,
   output logic       refresh_almost,
   output logic       refresh_urgent,
   output logic       busy,
   output logic       cmd_valid,
   output logic [1:0] cmd_type,
   output logic       refresh_done,
   output logic       refresh_err,
   output logic [3:0] pending
);
   typedef enum logic [2:0] {
      R_IDLE, R_COUNT, R_REQ, R_PREA, R_WAIT_RP, R_REF, R_WAIT_RFC, R_DONE
   } state_t;
   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d, cnt_q, cnt_d;
   logic [3:0]  pending_q, pending_d;
   logic        err_q, err_d, busy_q, busy_d, done_q, done_d, cmd_valid_q, cmd_valid_d;
   logic [1:0]  cmd_type_q, cmd_type_d;
   logic        idle, expire, is_ref, pulled_in;
   always_comb begin
      idle           = state_q == R_IDLE || !enable;
      expire         = timer_q == 16'(T_REFI - 1);
      is_ref         = state_q == R_REF;
      pulled_in      = is_ref && pending_q == 4'd0;
      refresh_almost = (state_q == R_COUNT || state_q == R_REQ) &&
                       (pending_q != 4'd0 || timer_q >= 16'(T_REFI - ALMOST_LEAD));
      refresh_urgent = pending_q >= 4'(MAX_POSTPONE);
      state_d        = state_q;
      cnt_d          = cnt_q + 16'd1;
      case (state_q)
         R_IDLE:     state_d = R_COUNT;
         R_COUNT:    state_d = refresh_almost ? R_REQ : R_COUNT;
         R_REQ:      state_d = refresh_grant ? R_PREA : R_REQ;
         R_PREA:     begin state_d = R_WAIT_RP; cnt_d = 16'd1; end
         R_WAIT_RP:  state_d = cnt_q >= 16'(T_RP - 1) ? R_REF : R_WAIT_RP;
         R_REF:      begin state_d = R_WAIT_RFC; cnt_d = 16'd1; end
         R_WAIT_RFC: state_d = cnt_q < 16'(T_RFC - 1) ? R_WAIT_RFC :
                               pending_q != 4'd0 ? R_REF : R_DONE;
         R_DONE:     state_d = R_COUNT;
         default:    state_d = R_IDLE;
      endcase
      if (!enable) state_d = R_IDLE;
      // A REF with nothing owed services the current interval early, so the
      // interval restarts; a REF coinciding with expiry cancels the increment.
      timer_d     = (idle || expire || pulled_in) ? 16'd0 : timer_q + 16'd1;
      pending_d   = (idle || pulled_in) ? 4'd0 :
                    (expire && !is_ref) ? (pending_q == 4'd9 ? 4'd9 : pending_q + 4'd1) :
                    (is_ref && !expire) ? pending_q - 4'd1 : pending_q;
      err_d       = err_q || (!idle && expire && pending_q == 4'd9);
      cmd_valid_d = state_d == R_PREA || state_d == R_REF;
      cmd_type_d  = state_d == R_PREA ? 2'd1 : state_d == R_REF ? 2'd2 : 2'd0;
      busy_d      = state_d inside {R_PREA, R_WAIT_RP, R_REF, R_WAIT_RFC, R_DONE};
      done_d      = state_d == R_DONE;
   end
   always_ff @(posedge CK_t or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= R_IDLE;
         timer_q     <= 16'd0;
         cnt_q       <= 16'd0;
         pending_q   <= 4'd0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_type_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_type_q  <= cmd_type_d;
      end
   end
   assign busy         = busy_q;
   assign cmd_valid    = cmd_valid_q;
   assign cmd_type     = cmd_type_q;
   assign refresh_done = done_q;
   assign refresh_err  = err_q;
   assign pending      = pending_q;
endmodule

// File: tb/tb_refresh_sched.sv
// tb_refresh_sched: directed refresh scenarios with small timing overrides plus
// a randomized grant/enable run checked against a cycle-scheduled reference model.
module tb_refresh_sched;
   localparam int TREFI = 100, LEAD = 10, TRP = 4, TRFC = 20;
   logic       CK_t = 1'b0, reset_n = 1'b0, enable = 1'b0, refresh_grant = 1'b0;
   logic       refresh_almost, refresh_urgent, busy, cmd_valid, refresh_done, refresh_err;
   logic [1:0] cmd_type;
   logic [3:0] pending;
   int         n_checks = 0, n_fail = 0;

   always #5 CK_t = ~CK_t;

   refresh_sched #(.T_REFI(TREFI), .ALMOST_LEAD(LEAD), .T_RP(TRP), .T_RFC(TRFC), .MAX_POSTPONE(8)) dut (
      .CK_t(CK_t), .reset_n(reset_n), .enable(enable), .refresh_grant(refresh_grant),
      .refresh_almost(refresh_almost), .refresh_urgent(refresh_urgent), .busy(busy),
      .cmd_valid(cmd_valid), .cmd_type(cmd_type), .refresh_done(refresh_done),
      .refresh_err(refresh_err), .pending(pending)
   );

   function automatic logic [11:0] obs();
      return {refresh_almost, refresh_urgent, busy, cmd_valid, cmd_type, refresh_done, refresh_err, pending};
   endfunction

   function automatic logic [11:0] pack(input logic alm, urg, bsy, input logic [1:0] ct,
                                        input logic dn, er, input logic [3:0] pnd);
      return {alm, urg, bsy, ct != 2'd0, ct, dn, er, pnd};
   endfunction

   task automatic tick();
      @(posedge CK_t);
      #2;
   endtask

   // Leaves the bench at cycle 0: first cycle in R_COUNT with the timer at 0.
   task automatic start();
      tick();
      reset_n = 1'b0;
      enable = 1'b0;
      refresh_grant = 1'b0;
      #2;
      reset_n = 1'b1;
      enable = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (obs() !== 12'd0) begin n_fail++; $display("FAIL reset_async got %b expected %b", obs(), 12'd0); end
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (obs() !== 12'd0) begin n_fail++; $display("FAIL reset_idle cycle %0d got %b expected %b", c, obs(), 12'd0); end
      end
   endtask

   task automatic test_pulled_in();
      logic [1:0] ct;
      logic [11:0] e;
      start();
      for (int c = 0; c <= 190; c++) begin
         ct = c == 93 ? 2'd1 : c == 97 ? 2'd2 : 2'd0;
         e = pack((c >= 90 && c <= 92) || c >= 188, 1'b0, c >= 93 && c <= 117, ct, c == 117, 1'b0, 4'd0);
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL pulled_in cycle %0d got %b expected %b", c, obs(), e); end
         refresh_grant = c == 92;
         tick();
      end
      refresh_grant = 1'b0;
   endtask

   task automatic test_postponed_burst();
      logic [1:0] ct;
      logic [3:0] p;
      logic [11:0] e;
      start();
      for (int c = 0; c <= 410; c++) begin
         ct = c == 306 ? 2'd1 : (c == 310 || c == 330 || c == 350) ? 2'd2 : 2'd0;
         p = c < 100 ? 4'd0 : c < 200 ? 4'd1 : c < 300 ? 4'd2 : c <= 310 ? 4'd3 :
             c <= 330 ? 4'd2 : c <= 350 ? 4'd1 : c < 400 ? 4'd0 : 4'd1;
         e = pack((c >= 90 && c <= 305) || c >= 390, 1'b0, c >= 306 && c <= 370, ct, c == 370, 1'b0, p);
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL postponed_burst cycle %0d got %b expected %b", c, obs(), e); end
         refresh_grant = c == 305;
         tick();
      end
      refresh_grant = 1'b0;
   endtask

   task automatic test_overflow();
      logic [3:0] p;
      logic [11:0] e;
      start();
      for (int c = 0; c <= 1010; c++) begin
         p = c >= 900 ? 4'd9 : 4'(c / 100);
         e = pack(c >= 90, p >= 4'd8, 1'b0, 2'd0, 1'b0, c >= 1000, p);
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL overflow cycle %0d got %b expected %b", c, obs(), e); end
         tick();
      end
      enable = 1'b0;
      tick();
      e = pack(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'd0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL err_retained got %b expected %b", obs(), e); end
   endtask

   task automatic test_grant_drop();
      logic [1:0] ct;
      logic [11:0] e;
      start();
      for (int c = 0; c <= 120; c++) begin
         ct = c == 92 ? 2'd1 : c == 96 ? 2'd2 : 2'd0;
         e = pack(c >= 90 && c <= 91, 1'b0, c >= 92 && c <= 116, ct, c == 116, 1'b0, 4'd0);
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL grant_drop cycle %0d got %b expected %b", c, obs(), e); end
         refresh_grant = c >= 91 && c <= 93;
         tick();
      end
   endtask

   task automatic test_enable_drop();
      logic [1:0] ct;
      logic [3:0] p;
      logic [11:0] e;
      start();
      for (int c = 0; c <= 290; c++) begin
         ct = c == 251 ? 2'd1 : c == 255 ? 2'd2 : 2'd0;
         p = c < 100 ? 4'd0 : c < 200 ? 4'd1 : c <= 255 ? 4'd2 : c <= 260 ? 4'd1 : 4'd0;
         e = pack(c >= 90 && c <= 250, 1'b0, c >= 251 && c <= 260, ct, 1'b0, 1'b0, p);
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL enable_drop cycle %0d got %b expected %b", c, obs(), e); end
         refresh_grant = c == 250;
         enable = c < 260;
         tick();
      end
      refresh_grant = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [11:0] e;
      start();
      for (int c = 0; c < 280; c++) begin
         refresh_grant = c == 250;
         tick();
      end
      refresh_grant = 1'b0;
      e = pack(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'd0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL burst_before_reset got %b expected %b", obs(), e); end
      reset_n = 1'b0;
      enable = 1'b0;
      #1;
      n_checks++;
      if (obs() !== 12'd0) begin n_fail++; $display("FAIL async_reset got %b expected %b", obs(), 12'd0); end
      tick();
      reset_n = 1'b1;
      enable = 1'b1;
      tick();
      for (int c = 0; c <= 95; c++) begin
         e = pack(c >= 90, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL reset_reenable cycle %0d got %b expected %b", c, obs(), e); end
         tick();
      end
   endtask

   // Reference model tracks absolute cycle numbers of scheduled commands.
   task automatic test_random();
      bit m_run = 1, m_req = 0, m_seq = 0, m_err = 0, alm, en, gr, expire, isref;
      int m_tmr = 0, m_pend = 0, p0, prea_c = -1, ref_c = -1, done_c = -1, gp = 0;
      logic [1:0] ct;
      logic [11:0] e;
      start();
      for (int c = 0; c < 4000; c++) begin
         if (c % 500 == 0) gp = $urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 1) == 0 ? 3 : 40;
         alm = m_run && !m_seq && (m_pend > 0 || m_tmr >= TREFI - LEAD);
         ct = (m_seq && c == prea_c) ? 2'd1 : (m_seq && c == ref_c) ? 2'd2 : 2'd0;
         e = pack(alm, m_pend >= 8, m_seq, ct, m_seq && c == done_c, m_err, 4'(m_pend));
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL random cycle %0d got %b expected %b", c, obs(), e); end
         en = $urandom_range(0, 599) != 0;
         gr = $urandom_range(0, 99) < gp;
         enable = en;
         refresh_grant = gr;
         if (!en) begin
            m_run = 0; m_req = 0; m_seq = 0; m_tmr = 0; m_pend = 0;
         end else if (!m_run) begin
            m_run = 1;
         end else begin
            p0 = m_pend;
            expire = m_tmr == TREFI - 1;
            isref = m_seq && c == ref_c;
            if (isref && p0 == 0) m_tmr = 0;
            else begin
               if (expire && p0 == 9) m_err = 1;
               m_pend = p0 + (expire ? 1 : 0) - (isref ? 1 : 0);
               if (m_pend > 9) m_pend = 9;
               m_tmr = expire ? 0 : m_tmr + 1;
            end
            if (m_seq) begin
               if (c == done_c) begin m_seq = 0; m_req = 0; end
               else if (c == ref_c + TRFC - 1) begin
                  if (p0 > 0) ref_c = c + 1;
                  else done_c = c + 1;
               end
            end else if (m_req && gr) begin
               m_seq = 1; prea_c = c + 1; ref_c = c + 1 + TRP; done_c = -1;
            end else if (alm) m_req = 1;
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_pulled_in();
      test_postponed_burst();
      test_overflow();
      test_grant_drop();
      test_enable_drop();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
